hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that consumes the ID/EX pipeline-register outputs, together with decode-stage and later-stage destination fields. It generates stall, bubble, flush and EX-operand forwarding controls for the 5-stage RV64 pipeline.

- Load-use hazards are handled by a small FSM with a configurable stall length, which models data-memory latency.
- A taken branch resolved in EX squashes the younger instructions in IF/ID and ID/EX.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal 1..7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rs1  in  5  rs1 field of the ID/EX register (rs1_d2).
- ex_rs2  in  5  rs2 field of the ID/EX register (rs2_d2).
- ex_rd  in  5  rd field of the ID/EX register (rd_d2).
- ex_mem_read  in  1  mem_read_d2.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_rd  in  5  EX/MEM destination register.
- mem_reg_write  in  1  EX/MEM reg_write.
- wb_rd  in  5  MEM/WB destination register.
- wb_reg_write  in  1  MEM/WB reg_write.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  load ID/EX with a bubble (all control bits 0).
- forward_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- forward_b  out  2  EX operand B select, same encoding as forward_a.
- stall_cnt  out  CNT_W  stalled-cycle count.
- flush_cnt  out  CNT_W  branch-flush count.

## Operation
Hazard terms:
- load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).

FSM state register, 1 bit: RUN, STALL. Down-counter rem, 3 bits.

RUN:
- If ex_branch_taken:
  - Outputs: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1.
  - Stay in RUN.
  - Branch flush has priority over load_use.
- Else if load_use:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - rem <= LOAD_STALL_CYCLES-1.
  - Next state is STALL if LOAD_STALL_CYCLES>1, else RUN.
- Else: pc_write=1, ifid_write=1, both flushes 0.

STALL:
- Outputs: pc_write=0, ifid_write=0, idex_flush=1. load_use is not re-evaluated.
- rem decrements each cycle.
- When rem==1 on entry to the cycle, next state is RUN.
- If ex_branch_taken is asserted in STALL (illegal, since EX holds a bubble): apply the RUN-branch outputs and go to RUN with rem <= 0.

Forwarding (combinational, independent of FSM):
- forward_a = 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
- Else forward_a = 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
- Else forward_a = 00.
- forward_b uses the same rules with ex_rs2.
- EX/MEM beats MEM/WB when both match. x0 is never forwarded.

## Timing
- Control outputs are Mealy: a combinational function of the registered state and the current inputs, with zero-cycle latency.
- A load-use hazard inserts exactly LOAD_STALL_CYCLES bubbles. The dependent instruction enters EX LOAD_STALL_CYCLES+1 cycles after the load did.
- A branch flush lasts exactly one cycle per taken branch.
- During and after reset: state=RUN, rem=0, counters=0.
  - With all inputs at 0: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, forward_a=00, forward_b=00, stall_cnt=0, flush_cnt=0.
- rst asserted mid-STALL returns the FSM to RUN immediately and asynchronously, with no residual bubbles.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every clk edge where pc_write==0.
  - flush_cnt increments on every edge where ifid_flush==1.
  - Both counters saturate at all-ones, are cleared by rst, and are registered (they reflect the previous cycle).
- HAZARD_PERF_CNT_EN undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

## Test plan
- Reset: assert rst with random inputs, release -> pc_write=1, ifid_write=1, flushes=0, forward=00, counters=0.
- Load-use, LOAD_STALL_CYCLES=1: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 -> one cycle of pc_write=0 and idex_flush=1, then RUN; stall_cnt=1.
- Load-use, LOAD_STALL_CYCLES=3, hazard inputs dropped after the first cycle -> exactly 3 bubble cycles; rst asserted in the 2nd cycle -> pc_write=1 immediately.
- Branch plus simultaneous load_use: ex_branch_taken=1 with a load_use match -> ifid_flush=1, idex_flush=1, pc_write=1, no STALL; flush_cnt=1, stall_cnt=0.
- Forward priority: mem_rd=7/wb_rd=7 both writing, ex_rs1=7 -> forward_a=10. mem_rd=0/wb_rd=0 writing, ex_rs2=0 -> forward_b=00. Only wb_rd=9 writing, ex_rs2=9 -> forward_b=01.
- Macro off: force 10 stalls -> stall_cnt stays 0. Macro on with CNT_W=2: 5 stalls -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//
// Hazard controller for the 5-stage RV64 pipeline. It produces these controls:
//   - stall controls (pc_write, ifid_write)
//   - bubble/squash controls (ifid_flush, idex_flush)
//   - EX-operand forwarding selects (forward_a, forward_b)
//
// Load-use hazards are held off by a small RUN/STALL FSM. The FSM inserts
// LOAD_STALL_CYCLES bubbles, which models data-memory latency. A taken branch
// resolved in EX squashes IF/ID and ID/EX for one cycle.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating
// stalled-cycle and branch-flush counters. When it is undefined, both counter
// outputs are tied to zero and no counter flops exist.
//
// Parameters:
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (legal range 1..7)
//   CNT_W              width of the performance counters
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   id_rs1/id_rs2                source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2      ID instruction actually reads that source
//   ex_rs1/ex_rs2/ex_rd          register fields held in ID/EX
//   ex_mem_read                  ID/EX instruction is a load
//   ex_branch_taken              branch in EX resolved taken
//   mem_rd/mem_reg_write         EX/MEM destination and write enable
//   wb_rd/wb_reg_write           MEM/WB destination and write enable
//   pc_write, ifid_write         PC / IF/ID update enables
//   ifid_flush, idex_flush       squash IF/ID, inject bubble into ID/EX
//   forward_a, forward_b         00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt, flush_cnt         performance counters (previous-cycle view)
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  // The RUN cycle that detects the hazard already emits the first bubble,
  // so the down-counter is loaded with one less than the total.
  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI    = (LOAD_STALL_CYCLES > 1);

  state_t     state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // State and bubble counter. An asynchronous reset drops straight back to
  // RUN, so a stall that is in progress leaves no further bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Mealy next-state and control outputs. A branch flush wins over a
  // load-use hazard. A branch seen while stalled cannot really happen,
  // because EX holds a bubble; it is still handled like a RUN branch so the
  // pipeline recovers cleanly.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    rem_nxt    = rem;
    unique case (state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          rem_nxt    = REM_INIT;
          state_nxt  = MULTI ? STALL : RUN;
        end
      end
      STALL: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          rem_nxt    = 3'd0;
          state_nxt  = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          rem_nxt    = rem - 3'd1;
          if (rem == 3'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Forwarding selects. The younger EX/MEM result takes precedence over
  // MEM/WB, and x0 is never forwarded because it always reads as zero.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
      forward_a = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      forward_a = 2'b01;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
      forward_b = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      forward_b = 2'b01;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters. They sample this cycle's controls at the edge, so
  // the outputs lag the controls by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Three instances share one set of inputs:
//   dut_a  LOAD_STALL_CYCLES=1
//   dut_c  LOAD_STALL_CYCLES=3
//   dut_s  LOAD_STALL_CYCLES=1, CNT_W=2 (counter saturation)
// Expected control vectors are queued when stimulus is driven and popped at
// the following negedge. The control vector packs these fields, MSB first:
// {pc_write, ifid_write, ifid_flush, idex_flush, forward_a, forward_b}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [7:0] RUNC = 8'b1100_0000;
  localparam logic [7:0] BUB  = 8'b0001_0000;
  localparam logic [7:0] BRF  = 8'b1111_0000;

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_u1, id_u2, ex_mr, br, mem_rw, wb_rw;
  } stim_t;

  typedef struct {
    string      name;
    logic [7:0] exp_a;
    logic [7:0] exp_c;
  } exp_t;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write;

  logic pcw_a, ifw_a, iff_a, ixf_a, pcw_c, ifw_c, iff_c, ixf_c;
  logic pcw_s, ifw_s, iff_s, ixf_s;
  logic [1:0] fa_a, fb_a, fa_c, fb_c, fa_s, fb_s;
  logic [31:0] scnt_a, fcnt_a, scnt_c, fcnt_c;
  logic [1:0]  scnt_s, fcnt_s;
  logic [7:0]  ctrl_a, ctrl_c, ctrl_s;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign ctrl_a = {pcw_a, ifw_a, iff_a, ixf_a, fa_a, fb_a};
  assign ctrl_c = {pcw_c, ifw_c, iff_c, ixf_c, fa_c, fb_c};
  assign ctrl_s = {pcw_s, ifw_s, iff_s, ixf_s, fa_s, fb_s};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pcw_a), .ifid_write(ifw_a), .ifid_flush(iff_a),
    .idex_flush(ixf_a), .forward_a(fa_a), .forward_b(fb_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pcw_c), .ifid_write(ifw_c), .ifid_flush(iff_c),
    .idex_flush(ixf_c), .forward_a(fa_c), .forward_b(fb_c),
    .stall_cnt(scnt_c), .flush_cnt(fcnt_c));

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pcw_s), .ifid_write(ifw_s), .ifid_flush(iff_s),
    .idex_flush(ixf_s), .forward_a(fa_s), .forward_b(fb_s),
    .stall_cnt(scnt_s), .flush_cnt(fcnt_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Load in EX writes x5, and the instruction in ID reads x5 through rs1.
  function automatic stim_t lu_stim();
    stim_t s;
    s = zero_stim();
    s.ex_mr  = 1'b1;
    s.ex_rd  = 5'd5;
    s.id_u1  = 1'b1;
    s.id_rs1 = 5'd5;
    return s;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] src,
                                         input logic [4:0] mrd, input logic mw,
                                         input logic [4:0] wrd, input logic ww);
    if (mw && mrd != 5'd0 && mrd == src) return 2'b10;
    if (ww && wrd != 5'd0 && wrd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_inputs(input stim_t s);
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_uses_rs1 = s.id_u1; id_uses_rs2 = s.id_u2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_mem_read = s.ex_mr; ex_branch_taken = s.br;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_rw;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_rw;
  endtask

  // Drives one cycle of stimulus just after the rising edge and queues the
  // controls expected for that cycle.
  task automatic apply(input stim_t s, input logic [7:0] ea,
                       input logic [7:0] ec, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    set_inputs(s);
    e.name = name; e.exp_a = ea; e.exp_c = ec;
    sb.push_back(e);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    set_inputs(zero_stim());
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t r;
    stim_t s;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      s.id_rs1 = 5'($urandom); s.id_rs2 = 5'($urandom);
      s.ex_rs1 = 5'($urandom); s.ex_rs2 = 5'($urandom);
      s.ex_rd = 5'($urandom); s.mem_rd = 5'($urandom); s.wb_rd = 5'($urandom);
      s.id_u1 = 1'($urandom); s.id_u2 = 1'($urandom); s.ex_mr = 1'($urandom);
      s.br = 1'($urandom); s.mem_rw = 1'($urandom); s.wb_rw = 1'($urandom);
      set_inputs(s);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) rst = 1'b0;
      apply(zero_stim(), RUNC, RUNC, (i == 0) ? "reset_held" : "reset_released");
      @(negedge clk);
      e = sb.pop_front();
      checks += 3;
      if (ctrl_a !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s dut_a: got %b expected %b", e.name, ctrl_a, e.exp_a); end
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s dut_c: got %b expected %b", e.name, ctrl_c, e.exp_c); end
      if (ctrl_s !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s dut_s: got %b expected %b", e.name, ctrl_s, e.exp_a); end
      checks++;
      if ({scnt_a, fcnt_a, scnt_c, fcnt_c, scnt_s, fcnt_s} !== 132'd0) begin errors++;
        $display("[TB] FAIL %s counters: got %0d/%0d/%0d/%0d/%0d/%0d expected all 0",
                 e.name, scnt_a, fcnt_a, scnt_c, fcnt_c, scnt_s, fcnt_s); end
    end
    r = '{name: "", exp_a: '0, exp_c: '0};
    r.name = "";
  endtask

  task automatic test_load_use();
    exp_t e;
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      apply((i == 0) ? lu_stim() : zero_stim(), (i == 0) ? BUB : RUNC,
            (i < 3) ? BUB : RUNC, "load_use");
      @(negedge clk);
      e = sb.pop_front();
      checks += 2;
      if (ctrl_a !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_a: got %b expected %b", e.name, i, ctrl_a, e.exp_a); end
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
    end
    checks += 2;
    if (scnt_a !== 32'(PERF * 1)) begin errors++;
      $display("[TB] FAIL load_use stall_cnt dut_a: got %0d expected %0d", scnt_a, PERF * 1); end
    if (scnt_c !== 32'(PERF * 3)) begin errors++;
      $display("[TB] FAIL load_use stall_cnt dut_c: got %0d expected %0d", scnt_c, PERF * 3); end
  endtask

  task automatic test_stall_reset();
    exp_t e;
    reset_pulse();
    for (int i = 0; i < 2; i++) begin
      apply((i == 0) ? lu_stim() : zero_stim(), (i == 0) ? BUB : RUNC, BUB, "stall_pre_reset");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
    end
    #1;
    rst = 1'b1;
    #1;
    checks += 2;
    if (ctrl_c !== RUNC) begin errors++;
      $display("[TB] FAIL async_reset dut_c: got %b expected %b", ctrl_c, RUNC); end
    if (scnt_c !== 32'd0) begin errors++;
      $display("[TB] FAIL async_reset stall_cnt dut_c: got %0d expected 0", scnt_c); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(zero_stim(), RUNC, RUNC, "stall_post_reset");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
    end
  endtask

  task automatic test_branch();
    exp_t  e;
    stim_t s;
    logic [7:0] ea[5];
    logic [7:0] ec[5];
    stim_t st[5];
    reset_pulse();
    s = lu_stim();
    s.br = 1'b1;
    st[0] = s;            ea[0] = BRF;  ec[0] = BRF;
    st[1] = zero_stim();  ea[1] = RUNC; ec[1] = RUNC;
    st[2] = lu_stim();    ea[2] = BUB;  ec[2] = BUB;
    s = zero_stim();
    s.br = 1'b1;
    st[3] = s;            ea[3] = BRF;  ec[3] = BRF;
    st[4] = zero_stim();  ea[4] = RUNC; ec[4] = RUNC;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ea[i], ec[i], "branch");
      @(negedge clk);
      e = sb.pop_front();
      checks += 2;
      if (ctrl_a !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_a: got %b expected %b", e.name, i, ctrl_a, e.exp_a); end
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
      if (i == 1) begin
        checks += 3;
        if (fcnt_a !== 32'(PERF)) begin errors++;
          $display("[TB] FAIL branch flush_cnt dut_a: got %0d expected %0d", fcnt_a, PERF); end
        if (scnt_a !== 32'd0) begin errors++;
          $display("[TB] FAIL branch stall_cnt dut_a: got %0d expected 0", scnt_a); end
        if (scnt_c !== 32'd0) begin errors++;
          $display("[TB] FAIL branch stall_cnt dut_c: got %0d expected 0", scnt_c); end
      end
    end
  endtask

  task automatic test_forwarding();
    exp_t  e;
    stim_t s;
    logic [1:0] fa, fb;
    for (int i = 0; i < 13; i++) begin
      s = zero_stim();
      case (i)
        0: begin s.mem_rd = 7; s.mem_rw = 1; s.wb_rd = 7; s.wb_rw = 1; s.ex_rs1 = 7; end
        1: begin s.mem_rw = 1; s.wb_rw = 1; s.ex_rs2 = 0; end
        2: begin s.mem_rd = 9; s.wb_rd = 9; s.wb_rw = 1; s.ex_rs2 = 9; s.ex_rs1 = 3; end
        3: begin s.mem_rd = 4; s.mem_rw = 1; s.wb_rd = 4; s.ex_rs1 = 4; s.ex_rs2 = 4; end
        4: begin s.mem_rd = 3; s.mem_rw = 1; s.wb_rd = 12; s.wb_rw = 1;
                 s.ex_rs1 = 12; s.ex_rs2 = 3; end
        default: begin
          s.mem_rd = 5'($urandom_range(0, 3)); s.wb_rd = 5'($urandom_range(0, 3));
          s.ex_rs1 = 5'($urandom_range(0, 3)); s.ex_rs2 = 5'($urandom_range(0, 3));
          s.mem_rw = 1'($urandom); s.wb_rw = 1'($urandom);
        end
      endcase
      fa = fwd_ref(s.ex_rs1, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
      fb = fwd_ref(s.ex_rs2, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
      apply(s, {4'b1100, fa, fb}, {4'b1100, fa, fb}, "forward");
      @(negedge clk);
      e = sb.pop_front();
      checks += 2;
      if (ctrl_a !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s vec%0d dut_a: got %b expected %b", e.name, i, ctrl_a, e.exp_a); end
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s vec%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    reset_pulse();
    for (int i = 0; i < 13; i++) begin
      apply((i < 10) ? lu_stim() : zero_stim(), (i < 10) ? BUB : RUNC,
            (i < 12) ? BUB : RUNC, "back_to_back");
      @(negedge clk);
      e = sb.pop_front();
      checks += 3;
      if (ctrl_a !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_a: got %b expected %b", e.name, i, ctrl_a, e.exp_a); end
      if (ctrl_c !== e.exp_c) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_c: got %b expected %b", e.name, i, ctrl_c, e.exp_c); end
      if (ctrl_s !== e.exp_a) begin errors++;
        $display("[TB] FAIL %s cyc%0d dut_s: got %b expected %b", e.name, i, ctrl_s, e.exp_a); end
      if (i == 10) begin
        checks += 3;
        if (scnt_a !== 32'(PERF * 10)) begin errors++;
          $display("[TB] FAIL b2b stall_cnt dut_a: got %0d expected %0d", scnt_a, PERF * 10); end
        if (scnt_c !== 32'(PERF * 10)) begin errors++;
          $display("[TB] FAIL b2b stall_cnt dut_c: got %0d expected %0d", scnt_c, PERF * 10); end
        if (scnt_s !== 2'(PERF * 3)) begin errors++;
          $display("[TB] FAIL b2b stall_cnt dut_s: got %0d expected %0d", scnt_s, PERF * 3); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_inputs(zero_stim());
    $display("[TB] starting hazard_ctrl bench, perf counters %0d", PERF);
    test_reset();
    test_load_use();
    test_stall_reset();
    test_branch();
    test_forwarding();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
